pll_reset_ctrl: RTL and testbench



---
 rtl/pll_ctrl_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_reset_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types and width helpers for the PLL reset/lock sequencer.
//   pll_state_e   : sequencer state with fixed encodings (visible on state_o)
//   timer_width() : timer width, $clog2 of the largest timing parameter (min 1)
//   count_width() : width needed to hold 0..n (min 1)
package pll_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

    function automatic int unsigned count_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : async active-low reset, both stages clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; only the second stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: reset and lock sequencer for the system PLL, clocked by the
// free-running board reference clock.
//   refclk     : 50 MHz reference clock (not PLL-derived)
//   rst_n      : async active-low reset
//   pll_locked : PLL lock indicator, asynchronous to refclk
//   relock_req : single-cycle request to re-run the PLL sequence (RUN/FAIL only)
//   pll_rst    : active-high PLL reset
//   sys_rst_n  : downstream active-low reset, released only in RUN
//   ready      : high in RUN
//   fail       : high in FAIL
//   state_o    : current state encoding
//   retry_cnt  : retries used in the current sequence
//   loss_cnt   : saturating count of lock-loss exits from RUN
//                (present only when PLLCTL_LOSS_CNT_EN is defined)
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               ready,
    output logic                               fail,
    output logic [STATE_W-1:0]                 state_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`ifdef PLLCTL_LOSS_CNT_EN
    ,
    output logic [7:0]                         loss_cnt
`endif
);

    localparam int unsigned TW  = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned RCW = $clog2(MAX_RETRIES + 1);

    pll_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d, timer_inc;
    logic [RCW-1:0]  retry_q, retry_d;
    logic            locked_s;
    logic            stable_done;
    logic            pll_rst_d, sys_rst_n_d, ready_d, fail_d;

    // Lock indicator into the refclk domain.
    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Saturating increment; the timer never wraps.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    // The WAIT_LOCK cycle that saw locked_s is the first stable cycle and the
    // current STABLE cycle is the last, so release once timer+2 reaches the target.
    assign stable_done = (32'(timer_q) + 32'd2) >= STABLE_CYCLES;

    // Next-state, timer and retry logic.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET: begin
                if (timer_q == TW'(RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q == RCW'(MAX_RETRIES)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RESET;
                        retry_d = retry_q + RCW'(1);
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (stable_done) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_RUN: begin
                // Lock loss and relock_req together still give a single restart.
                if (!locked_s || relock_req) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move with the state register.
    always_comb begin
        pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // State, timer and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst   <= pll_rst_d;
            sys_rst_n <= sys_rst_n_d;
            ready     <= ready_d;
            fail      <= fail_d;
        end
    end

    assign state_o   = state_q;
    assign retry_cnt = retry_q;

`ifdef PLLCTL_LOSS_CNT_EN
    // Counts only lock-loss exits from RUN; relock_req alone is not a loss.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if ((state_q == ST_RUN) && !locked_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed self-checking bench for pll_reset_ctrl with
// LOCK_TIMEOUT shortened to 200 cycles; other parameters at their defaults.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;
`ifdef PLLCTL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    pll_reset_ctrl #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (200),
        .STABLE_CYCLES (1024),
        .MAX_RETRIES   (3)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .state_o    (state_o),
        .retry_cnt  (retry_cnt)
`ifdef PLLCTL_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    // Waits at negedges for state_o to reach st; ok=0 if the budget runs out.
    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge refclk);
            if (state_o == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #6;
        vectors++; if (pll_rst !== 1'b1)   begin miscompares++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
        vectors++; if (sys_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
        vectors++; if (ready !== 1'b0)     begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
        vectors++; if (fail !== 1'b0)      begin miscompares++; $display("FAIL reset_fail got %b want 0", fail); end
        vectors++; if (state_o !== 3'd0)   begin miscompares++; $display("FAIL reset_state got %0d want 0", state_o); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
`ifdef PLLCTL_LOSS_CNT_EN
        vectors++; if (loss_cnt !== 8'd0)  begin miscompares++; $display("FAIL reset_loss got %0d want 0", loss_cnt); end
`endif
    endtask

    task automatic test_nominal_lock();
        int n;
        @(negedge refclk) rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (pll_rst) n++; else break;
            @(negedge refclk);
        end
        vectors++; if (n != 16) begin miscompares++; $display("FAIL nominal_rst_width got %0d want 16", n); end
        vectors++; if (state_o !== 3'd1) begin miscompares++; $display("FAIL nominal_wait_state got %0d want 1", state_o); end
        repeat (100) @(negedge refclk);
        pll_locked = 1'b1;
        // 2 synchronizer cycles plus 1024 stable cycles
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge refclk); #1;
            n++;
            if (sys_rst_n) break;
        end
        vectors++; if (n != 1026)          begin miscompares++; $display("FAIL nominal_release_delay got %0d want 1026", n); end
        vectors++; if (ready !== 1'b1)     begin miscompares++; $display("FAIL nominal_ready got %b want 1", ready); end
        vectors++; if (state_o !== 3'd3)   begin miscompares++; $display("FAIL nominal_state got %0d want 3", state_o); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL nominal_retry got %0d want 0", retry_cnt); end
        vectors++; if (pll_rst !== 1'b0)   begin miscompares++; $display("FAIL nominal_pll_rst got %b want 0", pll_rst); end
    endtask

    task automatic test_lock_loss();
        int n;
        bit ok;
        @(negedge refclk) pll_locked = 1'b0;
        @(posedge refclk);
        n = 1;
        @(negedge refclk) pll_locked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge refclk); #1;
            n++;
            if (!sys_rst_n) break;
        end
        vectors++; if (n != 3)           begin miscompares++; $display("FAIL loss_delay got %0d want 3", n); end
        vectors++; if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_pll_rst got %b want 1", pll_rst); end
        vectors++; if (state_o !== 3'd0) begin miscompares++; $display("FAIL loss_state got %0d want 0", state_o); end
        vectors++; if (ready !== 1'b0)   begin miscompares++; $display("FAIL loss_ready got %b want 0", ready); end
        wait_state(3'd3, 1500, ok);
        vectors++; if (!ok)              begin miscompares++; $display("FAIL loss_rerun state %0d want 3", state_o); end
        vectors++; if (sys_rst_n !== 1'b1) begin miscompares++; $display("FAIL loss_rerun_sys_rst_n got %b want 1", sys_rst_n); end
`ifdef PLLCTL_LOSS_CNT_EN
        vectors++; if (loss_cnt !== 8'd1) begin miscompares++; $display("FAIL loss_cnt got %0d want 1", loss_cnt); end
`endif
    endtask

    task automatic test_glitch_stable();
        int n;
        bit ok;
        @(negedge refclk) relock_req = 1'b1;
        @(negedge refclk) relock_req = 1'b0;
        vectors++; if (state_o !== 3'd0) begin miscompares++; $display("FAIL run_relock_state got %0d want 0", state_o); end
`ifdef PLLCTL_LOSS_CNT_EN
        vectors++; if (loss_cnt !== 8'd1) begin miscompares++; $display("FAIL run_relock_loss_cnt got %0d want 1", loss_cnt); end
`endif
        wait_state(3'd2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL glitch_reach_stable state %0d want 2", state_o); end
        repeat (500) @(negedge refclk);
        vectors++; if (state_o !== 3'd2) begin miscompares++; $display("FAIL glitch_still_stable got %0d want 2", state_o); end
        pll_locked = 1'b0;
        repeat (5) @(negedge refclk);
        vectors++; if (state_o !== 3'd1)   begin miscompares++; $display("FAIL glitch_state got %0d want 1", state_o); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL glitch_retry got %0d want 0", retry_cnt); end
        pll_locked = 1'b1;
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge refclk); #1;
            n++;
            if (sys_rst_n) break;
        end
        vectors++; if (n != 1026) begin miscompares++; $display("FAIL glitch_release_delay got %0d want 1026", n); end
    endtask

    task automatic test_relock_wait_lock();
        bit ok;
        @(negedge refclk) begin pll_locked = 1'b0; relock_req = 1'b1; end
        @(negedge refclk) relock_req = 1'b0;
        wait_state(3'd1, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wl_reach state %0d want 1", state_o); end
        repeat (10) @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk) relock_req = 1'b0;
        vectors++; if (state_o !== 3'd1)   begin miscompares++; $display("FAIL wl_relock_state got %0d want 1", state_o); end
        vectors++; if (pll_rst !== 1'b0)   begin miscompares++; $display("FAIL wl_relock_pll_rst got %b want 0", pll_rst); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL wl_relock_retry got %0d want 0", retry_cnt); end
    endtask

    task automatic test_no_lock();
        int n;
        pll_locked = 1'b0;
        @(negedge refclk) rst_n = 1'b0;
        @(negedge refclk) rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            for (int i = 0; i < 40; i++) begin
                if (!pll_rst) break;
                @(negedge refclk);
            end
            vectors++; if (pll_rst !== 1'b0)         begin miscompares++; $display("FAIL nolock_pulse%0d_end pll_rst %b want 0", a, pll_rst); end
            vectors++; if (retry_cnt !== 2'(a))      begin miscompares++; $display("FAIL nolock_retry%0d got %0d want %0d", a, retry_cnt, a); end
            n = 0;
            for (int i = 0; i < 300; i++) begin
                if (!pll_rst) n++; else break;
                @(negedge refclk);
            end
            vectors++; if (n != 200) begin miscompares++; $display("FAIL nolock_wait%0d got %0d want 200", a, n); end
            if (a < 3) begin
                vectors++; if (state_o !== 3'd0) begin miscompares++; $display("FAIL nolock_retry_state%0d got %0d want 0", a, state_o); end
                vectors++; if (retry_cnt !== 2'(a + 1)) begin miscompares++; $display("FAIL nolock_retry_inc%0d got %0d want %0d", a, retry_cnt, a + 1); end
            end
        end
        vectors++; if (state_o !== 3'd4)   begin miscompares++; $display("FAIL nolock_state got %0d want 4", state_o); end
        vectors++; if (fail !== 1'b1)      begin miscompares++; $display("FAIL nolock_fail got %b want 1", fail); end
        vectors++; if (pll_rst !== 1'b1)   begin miscompares++; $display("FAIL nolock_pll_rst got %b want 1", pll_rst); end
        vectors++; if (sys_rst_n !== 1'b0) begin miscompares++; $display("FAIL nolock_sys_rst_n got %b want 0", sys_rst_n); end
        vectors++; if (retry_cnt !== 2'd3) begin miscompares++; $display("FAIL nolock_retry_final got %0d want 3", retry_cnt); end
    endtask

    task automatic test_relock_fail();
        repeat (20) @(negedge refclk);
        vectors++; if (state_o !== 3'd4) begin miscompares++; $display("FAIL fail_hold got %0d want 4", state_o); end
        relock_req = 1'b1;
        @(posedge refclk); #1;
        vectors++; if (fail !== 1'b0)      begin miscompares++; $display("FAIL fail_relock_fail got %b want 0", fail); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL fail_relock_retry got %0d want 0", retry_cnt); end
        vectors++; if (state_o !== 3'd0)   begin miscompares++; $display("FAIL fail_relock_state got %0d want 0", state_o); end
        vectors++; if (pll_rst !== 1'b1)   begin miscompares++; $display("FAIL fail_relock_pll_rst got %b want 1", pll_rst); end
        @(negedge refclk) relock_req = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok;
        pll_locked = 1'b1;
        wait_state(3'd2, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL async_reach_stable state %0d want 2", state_o); end
        repeat (50) @(negedge refclk);
        @(posedge refclk);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (state_o !== 3'd0)   begin miscompares++; $display("FAIL async_state got %0d want 0", state_o); end
        vectors++; if (pll_rst !== 1'b1)   begin miscompares++; $display("FAIL async_pll_rst got %b want 1", pll_rst); end
        vectors++; if (sys_rst_n !== 1'b0) begin miscompares++; $display("FAIL async_sys_rst_n got %b want 0", sys_rst_n); end
`ifdef PLLCTL_LOSS_CNT_EN
        vectors++; if (loss_cnt !== 8'd0)  begin miscompares++; $display("FAIL async_loss_cnt got %0d want 0", loss_cnt); end
`endif
        @(negedge refclk) rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_lock_loss();
        test_glitch_stable();
        test_relock_wait_lock();
        test_no_lock();
        test_relock_fail();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
